// File: rtl/ps2_key_event_encoder.sv
// ---------------------------------------------------------------------------
// ps2_key_event_encoder
//
// Purpose:
//   Turns a stream of raw PS/2 set-2 scancode bytes into the 11-bit ps2_key
//   event word consumed by core-side keyboard handlers:
//       ps2_key[10]  toggle  - inverts on every event, so a consumer can
//                              detect new events without watching the strobe
//       ps2_key[9]   pressed - 1 for make, 0 for break (F0 prefix seen)
//       ps2_key[8]   ext     - 1 when the E0 extended prefix was seen
//       ps2_key[7:0] code    - the terminating scancode byte
//   The E0/F0 prefixes may arrive in either order and repeat harmlessly.
//   The eight-byte Pause sequence (E1 + 7 bytes) collapses into a single
//   "pressed, extended, 0x77" event and never produces a release.
//   Keyboard control/response bytes are swallowed and drop any prefix.
//   A prefix left dangling for TIMEOUT cycles without a new byte is dropped.
//
// Parameters:
//   TIMEOUT - idle clk_sys cycles before a pending prefix is discarded (>= 2)
//   TW      - width of the idle counter, 2**TW must exceed TIMEOUT
//
// Ports:
//   clk_sys    in   1   system clock, rising edge
//   reset      in   1   synchronous active-high reset
//   byte_in    in   8   received scancode byte
//   byte_valid in   1   one-cycle qualifier for byte_in (may be back to back)
//   ps2_key    out  11  {toggle, pressed, ext, code[7:0]}, holds between events
//   key_strobe out  1   one-cycle pulse coincident with each ps2_key update
//   busy       out  1   high while a prefix or Pause sequence is pending
// ---------------------------------------------------------------------------
module ps2_key_event_encoder #(
    parameter int TIMEOUT = 2457600,
    parameter int TW      = 22
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [10:0] ps2_key,
    output logic        key_strobe,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        PREFIX,
        PAUSE
    } state_t;

    localparam logic [7:0]    BYTE_EXT    = 8'hE0;
    localparam logic [7:0]    BYTE_BREAK  = 8'hF0;
    localparam logic [7:0]    BYTE_PAUSE  = 8'hE1;
    localparam logic [7:0]    PAUSE_CODE  = 8'h77;
    localparam logic [2:0]    PAUSE_SKIP  = 3'd7;
    localparam logic [TW-1:0] LAST_COUNT  = TW'(TIMEOUT - 1);

    state_t        r_state;
    logic          r_ext;
    logic          r_brk;
    logic [2:0]    r_skip;
    logic [TW-1:0] r_count;
    logic [10:0]   r_key;
    logic          r_strobe;
    logic          r_busy;

    state_t        w_nextState;
    logic          w_nextExt;
    logic          w_nextBrk;
    logic [2:0]    w_nextSkip;
    logic [TW-1:0] w_nextCount;
    logic          w_emit;
    logic          w_evPressed;
    logic          w_evExt;
    logic [7:0]    w_evCode;
    logic          w_isControl;

    // Bytes the keyboard sends as protocol responses rather than keys
    // (ACK, BAT result, echo, resend, errors). They never form an event.
    always_comb begin
        w_isControl = 1'b0;
        case (byte_in)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: w_isControl = 1'b1;
            default:                    w_isControl = 1'b0;
        endcase
    end

    // Next-state and event decode. A valid byte always takes priority over
    // the idle timeout, so a byte arriving on the expiry cycle is still
    // decoded with the prefix flags it was preceded by.
    always_comb begin
        w_nextState = r_state;
        w_nextExt   = r_ext;
        w_nextBrk   = r_brk;
        w_nextSkip  = r_skip;
        w_nextCount = r_count;
        w_emit      = 1'b0;
        w_evPressed = 1'b0;
        w_evExt     = 1'b0;
        w_evCode    = 8'h00;

        if (byte_valid) begin
            w_nextCount = '0;
            if (r_state == PAUSE) begin
                // Inside Pause every byte is just counted; the last one
                // stands in for the whole sequence.
                if (r_skip == 3'd1) begin
                    w_emit      = 1'b1;
                    w_evPressed = 1'b1;
                    w_evExt     = 1'b1;
                    w_evCode    = PAUSE_CODE;
                    w_nextSkip  = 3'd0;
                    w_nextState = IDLE;
                end else begin
                    w_nextSkip = r_skip - 3'd1;
                end
            end else if (byte_in == BYTE_EXT) begin
                w_nextExt   = 1'b1;
                w_nextState = PREFIX;
            end else if (byte_in == BYTE_BREAK) begin
                w_nextBrk   = 1'b1;
                w_nextState = PREFIX;
            end else if (byte_in == BYTE_PAUSE) begin
                // A Pause start abandons any half-built prefix.
                w_nextExt   = 1'b0;
                w_nextBrk   = 1'b0;
                w_nextSkip  = PAUSE_SKIP;
                w_nextState = PAUSE;
            end else if (w_isControl) begin
                w_nextExt   = 1'b0;
                w_nextBrk   = 1'b0;
                w_nextState = IDLE;
            end else begin
                w_emit      = 1'b1;
                w_evPressed = ~r_brk;
                w_evExt     = r_ext;
                w_evCode    = byte_in;
                w_nextExt   = 1'b0;
                w_nextBrk   = 1'b0;
                w_nextState = IDLE;
            end
        end else if (r_state != IDLE) begin
            // Stale prefix: the keyboard stopped mid-sequence, so drop it
            // rather than attach it to some unrelated later key.
            if (r_count == LAST_COUNT) begin
                w_nextExt   = 1'b0;
                w_nextBrk   = 1'b0;
                w_nextSkip  = 3'd0;
                w_nextCount = '0;
                w_nextState = IDLE;
            end else begin
                w_nextCount = r_count + TW'(1);
            end
        end
    end

    // State, flags and registered outputs. ps2_key is written in one go so
    // the toggle bit and the payload always change together.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state  <= IDLE;
            r_ext    <= 1'b0;
            r_brk    <= 1'b0;
            r_skip   <= 3'd0;
            r_count  <= '0;
            r_key    <= 11'h000;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_ext    <= w_nextExt;
            r_brk    <= w_nextBrk;
            r_skip   <= w_nextSkip;
            r_count  <= w_nextCount;
            r_strobe <= w_emit;
            r_busy   <= (w_nextState != IDLE);
            if (w_emit) begin
                r_key <= {~r_key[10], w_evPressed, w_evExt, w_evCode};
            end
        end
    end

    assign ps2_key    = r_key;
    assign key_strobe = r_strobe;
    assign busy       = r_busy;

endmodule

// File: tb/tb_ps2_key_event_encoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_event_encoder
//
// Drives scancode byte streams into ps2_key_event_encoder (TIMEOUT = 16) and
// compares its outputs against fixed expected words and against a byte-queue
// reference model that keeps the list of bytes seen since the last event.
// ---------------------------------------------------------------------------
module tb_ps2_key_event_encoder;

    localparam int TIMEOUT = 16;
    localparam int TW      = 5;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [10:0] ps2_key;
    logic        key_strobe;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: bytes pending since the last event/discard, the
    // expected ps2_key word, whether the last byte produced an event, and
    // the number of byte-free cycles since the last byte.
    logic [7:0]  pend[$];
    logic [10:0] mKey;
    logic        mEv;
    int          mGap;

    ps2_key_event_encoder #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .ps2_key    (ps2_key),
        .key_strobe (key_strobe),
        .busy       (busy)
    );

    // 100 MHz nominal clock; only cycle counts matter here
    always #5 clk_sys = ~clk_sys;

    function automatic logic isCtrl(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
               (b == 8'hFC) || (b == 8'hFD) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    function automatic logic pendHas(input logic [7:0] b);
        foreach (pend[i]) if (pend[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    // Decide what a byte means from the list of bytes pending before it
    task automatic modelByte(input logic [7:0] b);
        mEv  = 1'b0;
        mGap = 0;
        if (pend.size() > 0 && pend[0] == 8'hE1) begin
            if (pend.size() == 7) begin
                mEv  = 1'b1;
                mKey = {~mKey[10], 1'b1, 1'b1, 8'h77};
                pend.delete();
            end else begin
                pend.push_back(b);
            end
        end else if (b == 8'hE0 || b == 8'hF0) begin
            pend.push_back(b);
        end else if (b == 8'hE1) begin
            pend.delete();
            pend.push_back(b);
        end else if (isCtrl(b)) begin
            pend.delete();
        end else begin
            mEv  = 1'b1;
            mKey = {~mKey[10], ~pendHas(8'hF0), pendHas(8'hE0), b};
            pend.delete();
        end
    endtask

    task automatic doReset;
        reset      = 1'b1;
        byte_valid = 1'b0;
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        pend.delete();
        mKey = 11'h000;
        mEv  = 1'b0;
        mGap = 0;
    endtask

    // One byte on one clock; outputs are sampled 1 time unit after the edge
    task automatic applyStimulus(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk_sys);
        #1;
        byte_valid = 1'b0;
        modelByte(b);
    endtask

    task automatic idleCycle;
        byte_valid = 1'b0;
        @(posedge clk_sys);
        #1;
        mEv  = 1'b0;
        mGap = mGap + 1;
        if (mGap >= TIMEOUT) pend.delete();
    endtask

    task automatic test_reset;
        doReset();
        compared++;
        if (ps2_key !== 11'h000) begin
            mismatched++;
            $display("[TB] FAIL reset_key: got %h want %h", ps2_key, 11'h000);
        end
        compared++;
        if (key_strobe !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_strobe: got %b want 0", key_strobe);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_make;
        applyStimulus(8'h29);
        compared++;
        if (ps2_key !== 11'h629) begin
            mismatched++;
            $display("[TB] FAIL make_key: got %h want %h", ps2_key, 11'h629);
        end
        compared++;
        if (key_strobe !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL make_strobe: got %b want 1", key_strobe);
        end
        idleCycle();
        compared++;
        if (key_strobe !== 1'b0 || ps2_key !== 11'h629) begin
            mismatched++;
            $display("[TB] FAIL make_hold: got strobe %b key %h want 0 %h", key_strobe, ps2_key, 11'h629);
        end
    endtask

    task automatic test_break;
        applyStimulus(8'hF0);
        compared++;
        if (busy !== 1'b1 || key_strobe !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL break_prefix: got busy %b strobe %b want 1 0", busy, key_strobe);
        end
        applyStimulus(8'h29);
        compared++;
        if (ps2_key !== 11'h029 || key_strobe !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL break_key: got %h strobe %b want %h 1", ps2_key, key_strobe, 11'h029);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL break_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_extended;
        int strobes;
        strobes = 0;
        applyStimulus(8'hE0); strobes += int'(key_strobe);
        applyStimulus(8'h75); strobes += int'(key_strobe);
        compared++;
        if (ps2_key !== 11'h775) begin
            mismatched++;
            $display("[TB] FAIL ext_make: got %h want %h", ps2_key, 11'h775);
        end
        idleCycle();
        applyStimulus(8'hE0); strobes += int'(key_strobe);
        applyStimulus(8'hF0); strobes += int'(key_strobe);
        applyStimulus(8'h75); strobes += int'(key_strobe);
        compared++;
        if (ps2_key !== 11'h175) begin
            mismatched++;
            $display("[TB] FAIL ext_break_e0f0: got %h want %h", ps2_key, 11'h175);
        end
        idleCycle();
        applyStimulus(8'hF0); strobes += int'(key_strobe);
        applyStimulus(8'hE0); strobes += int'(key_strobe);
        applyStimulus(8'h6B); strobes += int'(key_strobe);
        // toggle 1, released, extended
        compared++;
        if (ps2_key !== 11'h56B) begin
            mismatched++;
            $display("[TB] FAIL ext_break_f0e0: got %h want %h", ps2_key, 11'h56B);
        end
        compared++;
        if (strobes != 3) begin
            mismatched++;
            $display("[TB] FAIL ext_strobe_count: got %0d want 3", strobes);
        end
    endtask

    task automatic test_pause;
        logic [7:0] seq[9];
        logic [9:0] evs[$];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h16};
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            if (key_strobe === 1'b1) evs.push_back(ps2_key[9:0]);
            if (i == 4) begin
                compared++;
                if (busy !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL pause_busy: got %b want 1", busy);
                end
            end
        end
        compared++;
        if (evs.size() != 2) begin
            mismatched++;
            $display("[TB] FAIL pause_event_count: got %0d want 2", evs.size());
        end else begin
            compared++;
            if (evs[0] !== 10'h377 || evs[1] !== 10'h216) begin
                mismatched++;
                $display("[TB] FAIL pause_events: got %h %h want %h %h", evs[0], evs[1], 10'h377, 10'h216);
            end
        end
    endtask

    task automatic test_timeout;
        doReset();
        applyStimulus(8'hE0);
        for (int i = 1; i <= 20; i++) begin
            idleCycle();
            compared++;
            if (busy !== (i < TIMEOUT)) begin
                mismatched++;
                $display("[TB] FAIL timeout_busy_%0d: got %b want %b", i, busy, (i < TIMEOUT));
            end
        end
        applyStimulus(8'h6B);
        compared++;
        if (ps2_key !== 11'h66B) begin
            mismatched++;
            $display("[TB] FAIL timeout_expired_key: got %h want %h", ps2_key, 11'h66B);
        end
        applyStimulus(8'hE0);
        for (int i = 1; i <= 15; i++) idleCycle();
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL timeout_edge_busy: got %b want 1", busy);
        end
        applyStimulus(8'h6B);
        compared++;
        if (ps2_key !== 11'h36B) begin
            mismatched++;
            $display("[TB] FAIL timeout_edge_key: got %h want %h", ps2_key, 11'h36B);
        end
    endtask

    task automatic test_control_and_reset;
        idleCycle();
        applyStimulus(8'hFA);
        compared++;
        if (key_strobe !== 1'b0 || ps2_key !== mKey) begin
            mismatched++;
            $display("[TB] FAIL control_byte: got strobe %b key %h want 0 %h", key_strobe, ps2_key, mKey);
        end
        applyStimulus(8'hF0);
        doReset();
        applyStimulus(8'h16);
        compared++;
        if (ps2_key !== 11'h616 || key_strobe !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_midseq: got %h strobe %b want %h 1", ps2_key, key_strobe, 11'h616);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  seq[4];
        logic        expStrobe[4];
        logic [10:0] expKey[4];
        seq       = '{8'h1C, 8'h1C, 8'hF0, 8'h1C};
        expStrobe = '{1'b1, 1'b1, 1'b0, 1'b1};
        expKey    = '{11'h61C, 11'h21C, 11'h21C, 11'h41C};
        doReset();
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            compared++;
            if (key_strobe !== expStrobe[i] || ps2_key !== expKey[i]) begin
                mismatched++;
                $display("[TB] FAIL b2b_%0d: got strobe %b key %h want %b %h", i, key_strobe, ps2_key, expStrobe[i], expKey[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] ctrl[8];
        logic [7:0] b;
        int         gap;
        int         r;
        ctrl = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
        doReset();
        for (int step = 0; step < 400; step++) begin
            r = int'($urandom_range(0, 9));
            gap = (r < 6) ? 0 : (r < 8) ? int'($urandom_range(1, 3)) : int'($urandom_range(14, 17));
            for (int g = 0; g < gap; g++) begin
                idleCycle();
                compared++;
                if (key_strobe !== 1'b0 || busy !== (pend.size() != 0)) begin
                    mismatched++;
                    $display("[TB] FAIL rand_idle_%0d: got strobe %b busy %b want 0 %b", step, key_strobe, busy, (pend.size() != 0));
                end
            end
            r = int'($urandom_range(0, 99));
            if (r < 15)      b = 8'hE0;
            else if (r < 30) b = 8'hF0;
            else if (r < 35) b = 8'hE1;
            else if (r < 42) b = ctrl[$urandom_range(0, 7)];
            else             b = 8'($urandom_range(0, 255));
            applyStimulus(b);
            compared++;
            if (key_strobe !== mEv || ps2_key !== mKey || busy !== (pend.size() != 0)) begin
                mismatched++;
                $display("[TB] FAIL rand_byte_%0d (%h): got strobe %b key %h busy %b want %b %h %b", step, b, key_strobe, ps2_key, busy, mEv, mKey, (pend.size() != 0));
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_pause();
        test_timeout();
        test_control_and_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
